// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder
// ----------------------------------------------------------------------------
// Responder end of the CPU MEM-stage data interface. Serves MemRead/MemWrite
// requests of word/halfword/byte size from a word-wide synchronous RAM.
// Sub-word stores are done as an internal read-modify-write. One word address
// (DISP_ADDR) is mapped to the display register DispReg.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned requests are dropped, Done still pulses, Fault is
//               set and stays set until reset.
//   undefined : alignment is forced by ignoring low address bits, Fault = 0.
//
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous active-low reset
//   MemRead      in   read request (accepted when Ready=1)
//   MemWrite     in   write request (wins over MemRead)
//   ByteSel      in   00 word, 01 halfword, 10 byte, 11 word
//   LoadUnsigned in   1 = zero-extend sub-word loads, 0 = sign-extend
//   Address      in   byte address
//   WriteData    in   store data (sub-word data from the low bits)
//   Ready        out  1 = a request is accepted this cycle
//   Done         out  one-cycle completion pulse
//   ReadData     out  load result, held until the next load completes
//   DispReg      out  memory-mapped display register
//   Fault        out  sticky misalignment flag
// ============================================================================
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] DISP_ADDR   = 32'h0000_FFF0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  ByteSel,
    input  logic        LoadUnsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        Ready,
    output logic        Done,
    output logic [31:0] ReadData,
    output logic [31:0] DispReg,
    output logic        Fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_MERGE = 2'd2
    } state_t;

    // Pick the addressed lane(s) out of a word and extend to 32 bits.
    function automatic logic [31:0] extractLoad(
        input logic [31:0] word,
        input logic [1:0]  sel,
        input logic [1:0]  lane,
        input logic        zeroExt
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sel)
            2'b01:   r = zeroExt ? {16'h0000, h} : {{16{h[15]}}, h};
            2'b10:   r = zeroExt ? {24'h00_0000, b} : {{24{b[7]}}, b};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane(s) of a word with the low bits of store data.
    function automatic logic [31:0] mergeStore(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  sel,
        input logic [1:0]  lane
    );
        logic [31:0] r;
        r = word;
        case (sel)
            2'b01: begin
                if (lane[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            2'b10:   r[{lane, 3'b000} +: 8] = wdata[7:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   ramQ_r;

    state_t        state_r;
    logic [AW-1:0] latIdx_r;
    logic [1:0]    latLane_r;
    logic [1:0]    latSel_r;
    logic          latUns_r;
    logic [31:0]   latWdata_r;
    logic          latDisp_r;

    logic          accept_s;
    logic          dispHit_s;
    logic          wordSize_s;
    logic          misalign_s;
    logic          doOp_s;
    logic [AW-1:0] idx_s;
    logic          ramWrEn_s;
    logic [AW-1:0] ramWrIdx_s;
    logic [31:0]   ramWrData_s;
    logic          ramRdEn_s;

    // Request decode for the current cycle.
    always_comb begin
        accept_s   = (state_r == ST_IDLE) && (MemRead || MemWrite);
        dispHit_s  = (Address[31:2] == DISP_ADDR[31:2]);
        wordSize_s = (ByteSel == 2'b00) || (ByteSel == 2'b11);
        idx_s      = Address[AW+1:2];
`ifdef MISALIGN_TRAP_EN
        if (wordSize_s) begin
            misalign_s = (Address[1:0] != 2'b00);
        end else if (ByteSel == 2'b01) begin
            misalign_s = Address[0];
        end else begin
            misalign_s = 1'b0;
        end
`else
        misalign_s = 1'b0;
`endif
        doOp_s = accept_s && !misalign_s;
    end

    // RAM port control: merge write-back has priority, it only occurs outside IDLE.
    always_comb begin
        ramWrEn_s   = 1'b0;
        ramWrIdx_s  = idx_s;
        ramWrData_s = WriteData;
        if (state_r == ST_MERGE) begin
            ramWrEn_s   = 1'b1;
            ramWrIdx_s  = latIdx_r;
            ramWrData_s = mergeStore(ramQ_r, latWdata_r, latSel_r, latLane_r);
        end else if (doOp_s && MemWrite && !dispHit_s && wordSize_s) begin
            ramWrEn_s = 1'b1;
        end else begin
            ramWrEn_s = 1'b0;
        end
        // Loads and sub-word stores both need the current word one edge later.
        ramRdEn_s = doOp_s && !dispHit_s && !(MemWrite && wordSize_s);
    end

    // Word RAM: one write and one registered read per cycle; writes blocked in reset.
    always_ff @(posedge Clock) begin
        if (ramWrEn_s && Reset) begin
            mem[ramWrIdx_s] <= ramWrData_s;
        end
        if (ramRdEn_s && Reset) begin
            ramQ_r <= mem[idx_s];
        end
    end

    // Control FSM with registered Ready/Done/ReadData/DispReg.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r    <= ST_IDLE;
            Ready      <= 1'b1;
            Done       <= 1'b0;
            ReadData   <= 32'h0000_0000;
            DispReg    <= 32'h0000_0000;
            latIdx_r   <= '0;
            latLane_r  <= 2'b00;
            latSel_r   <= 2'b00;
            latUns_r   <= 1'b0;
            latWdata_r <= 32'h0000_0000;
            latDisp_r  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        latIdx_r   <= idx_s;
                        latLane_r  <= Address[1:0];
                        latSel_r   <= ByteSel;
                        latUns_r   <= LoadUnsigned;
                        latWdata_r <= WriteData;
                        latDisp_r  <= dispHit_s;
                        if (misalign_s) begin
                            Done <= 1'b1;
                        end else if (MemWrite) begin
                            if (dispHit_s) begin
                                // Display store always takes the full word.
                                DispReg <= WriteData;
                                Done    <= 1'b1;
                            end else if (wordSize_s) begin
                                Done <= 1'b1;
                            end else begin
                                state_r <= ST_MERGE;
                                Ready   <= 1'b0;
                            end
                        end else begin
                            state_r <= ST_READ;
                            Ready   <= 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    // DispReg cannot change while a load is in flight.
                    ReadData <= extractLoad(latDisp_r ? DispReg : ramQ_r,
                                            latSel_r, latLane_r, latUns_r);
                    Done     <= 1'b1;
                    Ready    <= 1'b1;
                    state_r  <= ST_IDLE;
                end
                ST_MERGE: begin
                    Done    <= 1'b1;
                    Ready   <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    Ready   <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Fault <= 1'b0;
        end else if (accept_s && misalign_s) begin
            Fault <= 1'b1;
        end
    end
`else
    assign Fault = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam logic [31:0] DISP = 32'h0000_FFF0;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  ByteSel;
    logic        LoadUnsigned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        Ready;
    logic        Done;
    logic [31:0] ReadData;
    logic [31:0] DispReg;
    logic        Fault;

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .DISP_ADDR   (DISP)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .ByteSel      (ByteSel),
        .LoadUnsigned (LoadUnsigned),
        .Address      (Address),
        .WriteData    (WriteData),
        .Ready        (Ready),
        .Done         (Done),
        .ReadData     (ReadData),
        .DispReg      (DispReg),
        .Fault        (Fault)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] expRd;
        logic [31:0] expDisp;
        logic        expFault;
        int          doneCyc;
    } exp_t;

    exp_t sbQ[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: byte-addressed memory image plus visible registers.
    logic [7:0]  mdlBytes [0:4095];
    logic [31:0] mdlDisp  = 32'h0;
    logic [31:0] mdlRd    = 32'h0;
    logic        mdlFault = 1'b0;
    bit          trapEn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sizeOf(input logic [1:0] sel);
        if (sel == 2'b01) return 32'd2;
        else if (sel == 2'b10) return 32'd1;
        else return 32'd4;
    endfunction

    function automatic logic [7:0] getByte(input logic [31:0] a, input bit isDisp);
        logic [31:0] sh;
        if (isDisp) begin
            sh = mdlDisp >> (8 * a[1:0]);
            return sh[7:0];
        end
        return mdlBytes[a[11:0]];
    endfunction

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        exp_t e;
        if (Reset === 1'b1 && Done === 1'b1) begin
            if (sbQ.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got Done=1 expected no completion (t=%0t)", $time);
            end else begin
                e = sbQ.pop_front();
                chk("done_cycle", cyc, e.doneCyc);
                chk("read_data", ReadData, e.expRd);
                chk("disp_reg", DispReg, e.expDisp);
                chk("fault", {31'b0, Fault}, {31'b0, e.expFault});
            end
        end
    end

    // Issue one request at a falling edge once Ready is seen; update the model.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sel,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        int          budget;
        exp_t        e;
        logic [31:0] n, base, val, lat;
        bit          isDisp, mis;
        budget = 0;
        while (Ready !== 1'b1) begin
            @(negedge Clock);
            budget++;
            if (budget > 20) begin
                chk("ready_timeout", {31'b0, Ready}, 32'd1);
                return;
            end
        end
        MemRead = rd; MemWrite = wr; ByteSel = sel; LoadUnsigned = uns;
        Address = addr; WriteData = wd;

        n      = sizeOf(sel);
        base   = addr & ~(n - 32'd1);
        isDisp = ((addr & ~32'd3) == DISP);
        mis    = trapEn && ((addr & (n - 32'd1)) != 32'd0);
        lat    = 32'd2;
        if (mis) begin
            mdlFault = 1'b1;
            lat      = 32'd1;
        end else if (wr) begin
            if (isDisp) begin
                mdlDisp = wd;
                lat     = 32'd1;
            end else begin
                for (int i = 0; i < int'(n); i++)
                    mdlBytes[base[11:0] + 12'(i)] = 8'(wd >> (8 * i));
                lat = (n == 32'd4) ? 32'd1 : 32'd2;
            end
        end else begin
            val = 32'h0;
            for (int i = 0; i < int'(n); i++)
                val = val | ({24'h0, getByte(base + 32'(i), isDisp)} << (8 * i));
            if (!uns && n < 32'd4 && val[8 * n - 1])
                val = val | (32'hFFFF_FFFF << (8 * n));
            mdlRd = val;
        end
        e.expRd    = mdlRd;
        e.expDisp  = mdlDisp;
        e.expFault = mdlFault;
        e.doneCyc  = cyc + int'(lat);
        sbQ.push_back(e);
        @(negedge Clock);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    // Wait (bounded) until every expectation has been retired.
    task automatic waitIdle();
        int budget;
        budget = 0;
        while ((sbQ.size() != 0 || Ready !== 1'b1) && budget < 20) begin
            @(negedge Clock);
            budget++;
        end
        if (budget >= 20) chk("drain_timeout", 32'(sbQ.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] saved;
        logic [31:0] addr, w0;
        int          op;
`ifdef MISALIGN_TRAP_EN
        trapEn = 1'b1;
`else
        trapEn = 1'b0;
`endif
        Reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; ByteSel = 2'b00;
        LoadUnsigned = 1'b0; Address = 32'h0; WriteData = 32'h0;
        repeat (3) @(negedge Clock);
        chk("reset_ready", {31'b0, Ready}, 32'd1);
        chk("reset_done", {31'b0, Done}, 32'd0);
        chk("reset_readdata", ReadData, 32'h0);
        chk("reset_dispreg", DispReg, 32'h0);
        chk("reset_fault", {31'b0, Fault}, 32'd0);
        Reset = 1'b1;
        @(negedge Clock);

        // Fill the 16 words used below with back-to-back word stores.
        for (int i = 0; i < 16; i++)
            issue(1'b0, 1'b1, 2'b00, 1'b0, 32'(i * 4), 32'h1357_9BDF ^ 32'(i * 32'h0101_0101));
        w0 = 32'h1357_9BDF;
        waitIdle();

        // Word store then load.
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        waitIdle();
        chk("word_load", ReadData, 32'hDEAD_BEEF);

        // Byte RMW: Ready low for exactly one cycle, then signed byte load.
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h11, 32'h0000_0080);
        chk("rmw_ready_low", {31'b0, Ready}, 32'd0);
        @(negedge Clock);
        chk("rmw_ready_back", {31'b0, Ready}, 32'd1);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
        waitIdle();
        chk("byte_signed", ReadData, 32'hFFFF_FF80);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        waitIdle();
        chk("rmw_word", ReadData, 32'hDEAD_80EF);

        // Unsigned halfword load from the upper half.
        issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        waitIdle();
        chk("half_unsigned", ReadData, 32'h0000_DEAD);

        // Display register store and load back; word 0 untouched.
        issue(1'b0, 1'b1, 2'b00, 1'b0, DISP, 32'h0000_1234);
        waitIdle();
        chk("disp_store", DispReg, 32'h0000_1234);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        waitIdle();
        chk("word0_intact", ReadData, w0);
        issue(1'b1, 1'b0, 2'b00, 1'b0, DISP, 32'h0);
        waitIdle();
        chk("disp_load", ReadData, 32'h0000_1234);

        // Read+write together: only the write happens.
        issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h20, 32'h1111_2222);
        waitIdle();
        chk("prio_readdata_held", ReadData, 32'h0000_1234);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
        waitIdle();
        chk("prio_write", ReadData, 32'h1111_2222);

        // A request presented during MERGE is ignored.
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h24, 32'h0000_5A5A);
        MemWrite = 1'b1; ByteSel = 2'b00; Address = 32'h24; WriteData = 32'hBAD0_BAD0;
        @(negedge Clock);
        MemWrite = 1'b0;
        issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h24, 32'h0);
        waitIdle();
        chk("stall_ignored", ReadData, 32'h0000_5A5A);

        // Address wrap: 0x1010 aliases 0x0010.
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h1010, 32'hCAFE_F00D);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        waitIdle();
        chk("wrap_alias", ReadData, 32'hCAFE_F00D);

        // Reset during MERGE aborts the write-back.
        saved = {mdlBytes[12'h17], mdlBytes[12'h16], mdlBytes[12'h15], mdlBytes[12'h14]};
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h0000_0077);
        Reset = 1'b0;
        sbQ.delete();
        {mdlBytes[12'h17], mdlBytes[12'h16], mdlBytes[12'h15], mdlBytes[12'h14]} = saved;
        mdlDisp = 32'h0; mdlRd = 32'h0; mdlFault = 1'b0;
        @(negedge Clock);
        chk("abort_done", {31'b0, Done}, 32'd0);
        chk("abort_readdata", ReadData, 32'h0);
        chk("abort_dispreg", DispReg, 32'h0);
        chk("abort_ready", {31'b0, Ready}, 32'd1);
        Reset = 1'b1;
        @(negedge Clock);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h14, 32'h0);
        waitIdle();
        chk("abort_word_intact", ReadData, saved);

        // Misaligned word load: trapped when enabled, otherwise forced aligned.
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        waitIdle();
        chk("misalign_readdata", ReadData, 32'hCAFE_F00D);
        chk("misalign_fault", {31'b0, Fault}, {31'b0, trapEn});

        // Randomized traffic checked by the scoreboard.
        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 11) == 0)
                addr = DISP | 32'($urandom_range(0, 3));
            else
                addr = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2)
                       | 32'($urandom_range(0, 3));
            issue(op < 4 || op == 9, op >= 4, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), addr, $urandom);
        end
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU MEM-stage data interface. It accepts MemRead/MemWrite requests with ByteSel sizing and serves them from a word-wide synchronous RAM.
- Sub-word stores use an internal read-modify-write sequence.
- One word address is memory-mapped to a display register, DispReg, which feeds the seven-segment display driver.
- Sits between the EXMEM register outputs and the MEMWB register inputs, and supplies a Ready stall signal to the hazard logic.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit RAM words; must be a power of 2.
- DISP_ADDR, 32'h0000_FFF0, byte address of the display register (word-aligned).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  read request, qualified by Ready.
- MemWrite  in  1  write request, qualified by Ready.
- ByteSel  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- LoadUnsigned  in  1  1 = zero-extend sub-word loads; 0 = sign-extend.
- Address  in  32  byte address (ALU result).
- WriteData  in  32  store data; sub-word data is taken from the low bits.
- Ready  out  1  1 = a request is accepted this cycle.
- Done  out  1  one-cycle pulse when a request completes.
- ReadData  out  32  load result; holds until the next load completes.
- DispReg  out  32  memory-mapped display register.
- Fault  out  1  misalignment trap flag (see Optional Feature).

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to IDLE.
  - Ready=1, Done=0, ReadData=0, DispReg=0, Fault=0.
  - RAM contents are not cleared.
- Addressing:
  - Little-endian: Address[1:0]=00 selects byte lane [7:0].
  - Word index = Address[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap.
  - Alignment is forced: a halfword ignores Address[0]; a word ignores Address[1:0].
- Request accept: in IDLE with Ready=1, on the rising edge where MemRead|MemWrite=1.
  - Address, ByteSel, LoadUnsigned and WriteData are latched.
  - If MemRead and MemWrite are both 1, the write wins and the read is dropped.
- States:
  - IDLE: Ready=1.
  - READ: Ready=0.
  - MERGE: Ready=0.
- Word store to a RAM address:
  - RAM is written at the accept edge; state stays IDLE.
  - Done=1 in the following cycle.
  - Back-to-back word stores are sustained at 1 per cycle.
- Store to DISP_ADDR (any size):
  - DispReg <= WriteData (full 32 bits) at the accept edge; the RAM is not written.
  - Done=1 in the following cycle.
- Sub-word store to a RAM address:
  - Accept edge: issue the RAM read; go to MERGE.
  - MERGE edge: merge the selected lane(s) of WriteData into the read word, write it back, Done<=1, go to IDLE.
  - Total: 2 edges, Ready low for 1 cycle.
- Load:
  - Accept edge: issue the RAM read; go to READ.
  - READ edge: extract the lane, sign- or zero-extend, ReadData<=result, Done<=1, go to IDLE.
  - ReadData is valid and Done=1 in the cycle after the second edge.
  - A load from DISP_ADDR returns DispReg through the same 2-edge path.
- Requests presented while Ready=0 are ignored. The requester must hold the request until it sees Ready=1.
- Reset asserted during READ or MERGE aborts the operation. A pending MERGE write is not performed.
- Done is never high for two consecutive cycles for the same request.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A request with a misaligned address (halfword with Address[0]=1; word with Address[1:0]!=00) is not performed: no RAM/DispReg change and ReadData is unchanged.
  - Done still pulses in the next cycle.
  - Fault goes 1 and is sticky until reset.
- Undefined:
  - Alignment is forced as described under Behaviour.
  - Fault is tied to 0.

Test Plan:
- Word store then load:
  - Stimulus: store 32'hDEADBEEF to 0x0010, then load word from 0x0010.
  - Response: store Done 1 cycle after accept; ReadData=32'hDEADBEEF with Done 2 edges after load accept.
- Byte RMW and sign extension:
  - Stimulus: after the previous test, store byte 8'h80 to 0x0011, then signed byte load 0x0011.
  - Response: word at 0x0010 becomes 32'hDEAD80EF; ReadData=32'hFFFFFF80; Ready low exactly 1 cycle for the store.
- Halfword load:
  - Stimulus: unsigned halfword load from 0x0012.
  - Response: ReadData=32'h0000DEAD.
- Display register:
  - Stimulus: store 32'h00001234 to DISP_ADDR.
  - Response: DispReg=32'h00001234, word 0 of RAM unchanged; a load from DISP_ADDR returns 32'h00001234.
- Priority, stall and wrap:
  - Stimulus 1: MemRead=MemWrite=1.
  - Response 1: only the write occurs.
  - Stimulus 2: a request presented while in MERGE.
  - Response 2: it is ignored.
  - Stimulus 3: with DEPTH_WORDS=1024, a store to 0x1010.
  - Response 3: it aliases to 0x0010.
- Reset and trap:
  - Stimulus 1: assert Reset during MERGE.
  - Response 1: target word unchanged; Done=0, ReadData=0, DispReg=0.
  - Stimulus 2: with MISALIGN_TRAP_EN, a word load at 0x0013.
  - Response 2: Fault=1, ReadData unchanged.
